// File: rtl/init_chain_seq.sv
// Runtime init sequencer for the reg1..regN bank: on start, writes index k+1 to
// address k for every register over a valid/ready port, reporting done or timeout error.
module init_chain_seq #(
    parameter  int NUM_REGS = 5,
    parameter  int WIDTH    = 8,
    parameter  int TIMEOUT  = 16,
    localparam int AW       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
    localparam int CW       = (NUM_REGS > 0) ? $clog2(NUM_REGS + 1) : 1
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             start,
    output logic             wr_valid,
    input  logic             wr_ready,
    output logic [AW-1:0]    wr_addr,
    output logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CW-1:0]    count
);

    localparam int SW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2,
        ERROR = 2'd3
    } state_t;

    state_t          r_state;
    logic [SW-1:0]   r_stall;

    logic [AW-1:0]   w_next_addr;
    logic [SW-1:0]   w_stall_next;
    logic            w_last;
    logic            w_stall_hit;

    // Init value of register idx is idx+1, wrapping modulo 2^WIDTH.
    function automatic logic [WIDTH-1:0] init_val(input logic [AW-1:0] idx);
        logic [AW+WIDTH:0] v;
        v = {{(WIDTH + 1){1'b0}}, idx} + (AW + WIDTH + 1)'(1);
        return v[WIDTH-1:0];
    endfunction

    function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] s);
        return (s == SW'(TIMEOUT)) ? s : s + SW'(1);
    endfunction

    assign w_next_addr  = wr_addr + AW'(1);
    assign w_last       = (wr_addr == AW'(NUM_REGS - 1));
    assign w_stall_next = sat_inc(r_stall);
    assign w_stall_hit  = (w_stall_next == SW'(TIMEOUT));

    assign busy = (r_state == WRITE);
    assign done = (r_state == DONE);
    assign err  = (r_state == ERROR);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_stall  <= '0;
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            count    <= '0;
        end else begin
            case (r_state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        r_state  <= WRITE;
                        r_stall  <= '0;
                        wr_valid <= 1'b1;
                        wr_addr  <= '0;
                        wr_data  <= init_val('0);
                        count    <= '0;
                    end
                end
                WRITE: begin
                    // wr_valid is always high here, so wr_ready alone marks a handshake.
                    if (wr_ready) begin
                        r_stall <= '0;
                        count   <= count + CW'(1);
                        if (w_last) begin
                            r_state  <= DONE;
                            wr_valid <= 1'b0;
                        end else begin
                            wr_addr <= w_next_addr;
                            wr_data <= init_val(w_next_addr);
                        end
                    end else begin
                        r_stall <= w_stall_next;
                        if (w_stall_hit) begin
                            r_state  <= ERROR;
                            wr_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    wr_valid <= 1'b0;
                end
            endcase
        end
    end

    // A pending write keeps its address and data until accepted or abandoned.
    a_hold_stable: assert property (@(posedge clock) disable iff (!rst_n)
        (wr_valid && !wr_ready) |=> (!wr_valid || ($stable(wr_addr) && $stable(wr_data))));

    a_valid_busy: assert property (@(posedge clock) disable iff (!rst_n)
        wr_valid == busy);

endmodule

// File: tb/tb_init_chain_seq.sv
// Randomized bench for init_chain_seq: two instances (WIDTH 8 and 2) share stimulus
// and are compared every cycle against a sequence-level reference model.
module tb_init_chain_seq;

    localparam int N = 5;
    localparam int T = 16;

    logic       clock = 1'b0;
    logic       rst_n;
    logic       start;
    logic       wr_ready;

    logic       a_valid, a_busy, a_done, a_err;
    logic [2:0] a_addr;
    logic [7:0] a_data;
    logic [2:0] a_count;

    logic       b_valid, b_busy, b_done, b_err;
    logic [2:0] b_addr;
    logic [1:0] b_data;
    logic [2:0] b_count;

    int n_err = 0;
    int n_chk = 0;

    // Reference model: sequence active, writes accepted so far, current stall run, outcome.
    bit m_act, m_done, m_err, m_fresh;
    int m_idx, m_stall;

    always #5 clock = ~clock;

    init_chain_seq #(.NUM_REGS(N), .WIDTH(8), .TIMEOUT(T)) u_dut_a (
        .clock(clock), .rst_n(rst_n), .start(start),
        .wr_valid(a_valid), .wr_ready(wr_ready), .wr_addr(a_addr), .wr_data(a_data),
        .busy(a_busy), .done(a_done), .err(a_err), .count(a_count)
    );

    init_chain_seq #(.NUM_REGS(N), .WIDTH(2), .TIMEOUT(T)) u_dut_b (
        .clock(clock), .rst_n(rst_n), .start(start),
        .wr_valid(b_valid), .wr_ready(wr_ready), .wr_addr(b_addr), .wr_data(b_data),
        .busy(b_busy), .done(b_done), .err(b_err), .count(b_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_act = 0; m_done = 0; m_err = 0; m_fresh = 1;
        m_idx = 0; m_stall = 0;
    endtask

    task automatic model_step(input bit s, input bit r);
        if (m_act) begin
            if (r) begin
                m_idx++;
                m_stall = 0;
                if (m_idx == N) begin
                    m_act  = 0;
                    m_done = 1;
                end
            end else begin
                m_stall++;
                if (m_stall == T) begin
                    m_act = 0;
                    m_err = 1;
                end
            end
        end else if (s) begin
            m_act = 1; m_done = 0; m_err = 0; m_fresh = 0;
            m_idx = 0; m_stall = 0;
        end
    endtask

    task automatic check_all();
        int ea;
        ea = m_done ? N - 1 : m_idx;
        chk("valid", 32'(a_valid), 32'(m_act));
        chk("busy",  32'(a_busy),  32'(m_act));
        chk("done",  32'(a_done),  32'(m_done));
        chk("err",   32'(a_err),   32'(m_err));
        chk("addr",  32'(a_addr),  32'(ea));
        chk("data",  32'(a_data),  m_fresh ? 32'd0 : 32'((ea + 1) % 256));
        chk("count", 32'(a_count), 32'(m_idx));
        chk("w2_valid", 32'(b_valid), 32'(m_act));
        chk("w2_done",  32'(b_done),  32'(m_done));
        chk("w2_err",   32'(b_err),   32'(m_err));
        chk("w2_data",  32'(b_data),  m_fresh ? 32'd0 : 32'((ea + 1) % 4));
        chk("w2_count", 32'(b_count), 32'(m_idx));
    endtask

    task automatic cyc(input bit s, input bit r);
        @(negedge clock);
        check_all();
        start    = s;
        wr_ready = r;
        model_step(s, r);
    endtask

    task automatic reset_mid();
        @(posedge clock);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clock);
        start = 1'b0;
        check_all();
        rst_n = 1'b1;
    endtask

    initial begin
        int st;
        int mode;
        bit r;
        rst_n = 1'b0;
        start = 1'b0;
        wr_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clock);
        check_all();
        rst_n = 1'b1;

        // full run with ready high
        cyc(1, 1);
        repeat (8) cyc(0, 1);

        // ready low for 3 cycles on address 2
        cyc(1, 1);
        st = 0;
        for (int k = 0; k < 12; k++) begin
            if (m_act && m_idx == 2 && st < 3) begin
                st++;
                cyc(0, 0);
            end else begin
                cyc(0, 1);
            end
        end

        // stuck low from address 1, then restart
        cyc(1, 0);
        cyc(0, 1);
        repeat (20) cyc(0, 0);
        cyc(1, 1);
        repeat (7) cyc(0, 1);

        // TIMEOUT-1 stalled cycles then acceptance
        cyc(1, 0);
        repeat (T - 1) cyc(0, 0);
        repeat (7) cyc(0, 1);

        // start during WRITE ignored, start in DONE restarts
        cyc(1, 1);
        cyc(0, 1);
        cyc(1, 1);
        repeat (5) cyc(0, 1);
        cyc(1, 1);
        repeat (7) cyc(0, 1);

        // async reset while holding address 3
        cyc(1, 1);
        repeat (3) cyc(0, 1);
        cyc(0, 0);
        reset_mid();
        repeat (3) cyc(0, 1);

        for (int seg = 0; seg < 40; seg++) begin
            mode = int'($urandom_range(0, 3));
            for (int k = 0; k < 30; k++) begin
                case (mode)
                    0:       r = 1'b1;
                    1:       r = ($urandom_range(0, 3) != 0);
                    2:       r = ($urandom_range(0, 3) == 0);
                    default: r = 1'b0;
                endcase
                cyc($urandom_range(0, 7) == 0, r);
                if ($urandom_range(0, 59) == 0) reset_mid();
            end
        end

        @(negedge clock);
        check_all();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
